// File: rtl/ray_scan_generator.sv
// ray_scan_generator: raster scanner and 4-stage primary-ray pipeline (CAMERA_ROTATE_EN enables the world-space basis transform)
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 4
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 2
`endif

module ray_scan_generator #(
    parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
    parameter int XW            = $clog2(SCREEN_WIDTH),
    parameter int YW            = $clog2(SCREEN_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          abort,
    input  logic [95:0]   camera_right,
    input  logic [95:0]   camera_up,
    input  logic [95:0]   camera_forward,
    input  logic [31:0]   tan_half_fov,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [95:0]   ray_dir,
    output logic [31:0]   ray_mag_sq,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_eol,
    output logic          out_eof,
    output logic          busy,
    output logic          frame_done
);
    localparam logic [31:0]   FP_ONE = 32'h0100_0000;
    localparam logic [31:0]   INV_W  = 32'((16777216 + SCREEN_WIDTH / 2) / SCREEN_WIDTH);
    localparam logic [31:0]   INV_H  = 32'((16777216 + SCREEN_HEIGHT / 2) / SCREEN_HEIGHT);
    localparam logic [63:0]   ASP64  = (64'(SCREEN_WIDTH) << 24) / 64'(SCREEN_HEIGHT);
    localparam logic [31:0]   ASPECT = ASP64[31:0];
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[55:24];
    endfunction

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          done_q, done_d;
    logic [31:0]   tan_q;
    logic          adv, issue, accept, latch, scan_eol, scan_eof;

    logic          v1_q, eol1_q, eof1_q;
    logic [31:0]   ndcx1_q, ndcy1_q, ndcx1_d, ndcy1_d;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y1_q;
    logic          v2_q, eol2_q, eof2_q;
    logic [31:0]   cx2_q, cy2_q, cx2_d, cy2_d;
    logic [XW-1:0] x2_q;
    logic [YW-1:0] y2_q;
    logic          v3_q, eol3_q, eof3_q;
    logic [31:0]   wx3_q, wy3_q, wz3_q, wx3_d, wy3_d, wz3_d;
    logic [XW-1:0] x3_q;
    logic [YW-1:0] y3_q;
    logic          v4_q, eol4_q, eof4_q;
    logic [95:0]   dir4_q;
    logic [31:0]   mag4_q, mag4_d;
    logic [XW-1:0] x4_q;
    logic [YW-1:0] y4_q;
    logic [31:0]   px, py;

`ifdef CAMERA_ROTATE_EN
    logic [95:0]   right_q, up_q, fwd_q;
`else
    logic          unused_camera;
    assign unused_camera = ^{camera_right, camera_up, camera_forward};
`endif

    assign adv      = !v4_q || out_ready;
    assign accept   = v4_q && out_ready;
    assign scan_eol = x_q == X_LAST;
    assign scan_eof = scan_eol && (y_q == Y_LAST);

    // Scanner FSM: raster walk in RUN, wait for the eof handshake in DRAIN; abort overrides all
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        issue   = 1'b0;
        case (state_q)
            IDLE:  state_d = frame_start ? RUN : IDLE;
            RUN: begin
                if (adv) begin
                    issue = 1'b1;
                    x_d   = scan_eol ? '0 : x_q + 1'b1;
                    y_d   = scan_eof ? '0 : (scan_eol ? y_q + 1'b1 : y_q);
                    if (scan_eof) state_d = DRAIN;
                end
            end
            DRAIN: state_d = (accept && eof4_q) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        latch  = (state_q == IDLE) && frame_start && !abort;
        done_d = (state_q == DRAIN) && accept && eof4_q && !abort;
        if (abort) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            issue   = 1'b0;
        end
    end

    // Scanner state, counters, done pulse and per-frame camera latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            tan_q   <= '0;
`ifdef CAMERA_ROTATE_EN
            right_q <= '0;
            up_q    <= '0;
            fwd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            if (latch) begin
                tan_q   <= tan_half_fov;
`ifdef CAMERA_ROTATE_EN
                right_q <= camera_right;
                up_q    <= camera_up;
                fwd_q   <= camera_forward;
`endif
            end
        end
    end

    // Stage datapaths: pixel-centre NDC, camera-space scale, world transform, squared magnitude
    always_comb begin
        px      = {{(31 - XW){1'b0}}, x_q, 1'b1};
        py      = {{(31 - YW){1'b0}}, y_q, 1'b1};
        ndcx1_d = px * INV_W - FP_ONE;
        ndcy1_d = FP_ONE - py * INV_H;
        cx2_d   = fp_mul(fp_mul(ndcx1_q, ASPECT), tan_q);
        cy2_d   = fp_mul(ndcy1_q, tan_q);
`ifdef CAMERA_ROTATE_EN
        wx3_d   = fp_mul(cx2_q, right_q[95:64]) + fp_mul(cy2_q, up_q[95:64]) + fwd_q[95:64];
        wy3_d   = fp_mul(cx2_q, right_q[63:32]) + fp_mul(cy2_q, up_q[63:32]) + fwd_q[63:32];
        wz3_d   = fp_mul(cx2_q, right_q[31:0]) + fp_mul(cy2_q, up_q[31:0]) + fwd_q[31:0];
`else
        wx3_d   = cx2_q;
        wy3_d   = cy2_q;
        wz3_d   = -FP_ONE;
`endif
        mag4_d  = fp_mul(wx3_q, wx3_q) + fp_mul(wy3_q, wy3_q) + fp_mul(wz3_q, wz3_q);
    end

    // Pipeline registers: flushed by abort, otherwise advance together when downstream can take a beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {v1_q, eol1_q, eof1_q, ndcx1_q, ndcy1_q, x1_q, y1_q} <= '0;
            {v2_q, eol2_q, eof2_q, cx2_q, cy2_q, x2_q, y2_q}     <= '0;
            {v3_q, eol3_q, eof3_q, wx3_q, wy3_q, wz3_q, x3_q, y3_q} <= '0;
            {v4_q, eol4_q, eof4_q, dir4_q, mag4_q, x4_q, y4_q}   <= '0;
        end else if (abort) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
        end else if (adv) begin
            v1_q    <= issue;
            ndcx1_q <= ndcx1_d;
            ndcy1_q <= ndcy1_d;
            x1_q    <= x_q;
            y1_q    <= y_q;
            eol1_q  <= scan_eol;
            eof1_q  <= scan_eof;
            v2_q    <= v1_q;
            cx2_q   <= cx2_d;
            cy2_q   <= cy2_d;
            x2_q    <= x1_q;
            y2_q    <= y1_q;
            eol2_q  <= eol1_q;
            eof2_q  <= eof1_q;
            v3_q    <= v2_q;
            wx3_q   <= wx3_d;
            wy3_q   <= wy3_d;
            wz3_q   <= wz3_d;
            x3_q    <= x2_q;
            y3_q    <= y2_q;
            eol3_q  <= eol2_q;
            eof3_q  <= eof2_q;
            v4_q    <= v3_q;
            dir4_q  <= {wx3_q, wy3_q, wz3_q};
            mag4_q  <= mag4_d;
            x4_q    <= x3_q;
            y4_q    <= y3_q;
            eol4_q  <= eol3_q;
            eof4_q  <= eof3_q;
        end
    end

    assign out_valid  = v4_q;
    assign ray_dir    = dir4_q;
    assign ray_mag_sq = mag4_q;
    assign out_x      = x4_q;
    assign out_y      = y4_q;
    assign out_eol    = eol4_q;
    assign out_eof    = eof4_q;
    assign busy       = state_q != IDLE;
    assign frame_done = done_q;
endmodule
